// File: rtl/guia05_pkg.sv
// Shared definitions for the NOR vector checker stages.
package guia05_pkg;

   // FSM state encoding
   localparam logic [1:0] ST_IDLE_ENC   = 2'd0;
   localparam logic [1:0] ST_WAIT_ENC   = 2'd1;
   localparam logic [1:0] ST_SAMPLE_ENC = 2'd2;
   localparam logic [1:0] ST_DONE_ENC   = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE   = ST_IDLE_ENC,
      ST_WAIT   = ST_WAIT_ENC,
      ST_SAMPLE = ST_SAMPLE_ENC,
      ST_DONE   = ST_DONE_ENC
   } state_t;

   // Legal settle range; the timer counter is sized to cover SETTLE_MAX
   localparam int unsigned SETTLE_MIN = 1;
   localparam int unsigned SETTLE_MAX = 15;
   localparam int unsigned TIMER_W    = 4;

   // Widest vector the golden function accepts (callers zero-extend)
   localparam int unsigned NOR_MAX_W  = 32;

   // Golden N-input NOR
   function automatic logic nor_ref(input logic [NOR_MAX_W-1:0] vec);
      return ~|vec;
   endfunction

endpackage

// File: rtl/nor_vector_checker_settle_timer.sv
// Settle-time counter: hit marks the last cycle of a SETTLE-cycle hold.
module settle_timer
   import guia05_pkg::*;
#(
   parameter int unsigned SETTLE = 1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic hit
);

   logic [TIMER_W-1:0] count;

   // Counter: clear has priority over enable
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (en) begin
         count <= count + TIMER_W'(1);
      end
   end

   assign hit = (count == TIMER_W'(SETTLE - 1));

endmodule

// File: rtl/nor_vector_checker.sv
// Clocked exhaustive-vector checker for a pair of N-input NOR implementations.
module nor_vector_checker
   import guia05_pkg::*;
#(
   parameter int unsigned N      = 2,
   parameter int unsigned SETTLE = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   output logic [N-1:0] x,
   input  logic         a,
   input  logic         b,
   output logic         busy,
   output logic         done,
   output logic         pass,
   output logic [N:0]   err_count,
   output logic         mism_a,
   output logic         mism_b,
   output logic [N-1:0] first_err_vec,
   output logic         first_err_valid
);

   localparam int unsigned CNT_W = N + 1;

   state_t       state, state_nxt;
   logic [N-1:0] x_nxt;
   logic [N:0]   err_nxt;
   logic         mism_a_nxt, mism_b_nxt;
   logic [N-1:0] fev_nxt;
   logic         fev_valid_nxt;
   logic         tmr_clr, tmr_en, tmr_hit;
   logic         golden, bad_a, bad_b;

   settle_timer #(.SETTLE(SETTLE)) u_settle_timer (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (tmr_clr),
      .en    (tmr_en),
      .hit   (tmr_hit)
   );

   assign golden = nor_ref(NOR_MAX_W'(x));
   assign bad_a  = (a != golden);
   assign bad_b  = (b != golden);

   // Next-state, vector stepping and result accumulation
   always_comb begin
      state_nxt     = state;
      x_nxt         = x;
      err_nxt       = err_count;
      mism_a_nxt    = mism_a;
      mism_b_nxt    = mism_b;
      fev_nxt       = first_err_vec;
      fev_valid_nxt = first_err_valid;
      tmr_clr       = 1'b0;
      tmr_en        = 1'b0;

      case (state)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               state_nxt     = ST_WAIT;
               x_nxt         = '0;
               err_nxt       = '0;
               mism_a_nxt    = 1'b0;
               mism_b_nxt    = 1'b0;
               fev_nxt       = '0;
               fev_valid_nxt = 1'b0;
               tmr_clr       = 1'b1;
            end
         end
         ST_WAIT: begin
            tmr_en = 1'b1;
            if (tmr_hit) begin
               state_nxt = ST_SAMPLE;
            end
         end
         ST_SAMPLE: begin
            tmr_clr    = 1'b1;
            mism_a_nxt = mism_a | bad_a;
            mism_b_nxt = mism_b | bad_b;
            if (bad_a || bad_b) begin
               err_nxt = err_count + CNT_W'(1);
               if (!first_err_valid) begin
                  fev_nxt       = x;
                  fev_valid_nxt = 1'b1;
               end
            end
            if (x == {N{1'b1}}) begin
               state_nxt = ST_DONE;
            end else begin
               state_nxt = ST_WAIT;
               x_nxt     = x + N'(1);
            end
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   // State and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state           <= ST_IDLE;
         x               <= '0;
         err_count       <= '0;
         mism_a          <= 1'b0;
         mism_b          <= 1'b0;
         first_err_vec   <= '0;
         first_err_valid <= 1'b0;
         busy            <= 1'b0;
         done            <= 1'b0;
      end else begin
         state           <= state_nxt;
         x               <= x_nxt;
         err_count       <= err_nxt;
         mism_a          <= mism_a_nxt;
         mism_b          <= mism_b_nxt;
         first_err_vec   <= fev_nxt;
         first_err_valid <= fev_valid_nxt;
         busy            <= (state_nxt == ST_WAIT) || (state_nxt == ST_SAMPLE);
         done            <= (state_nxt == ST_DONE);
      end
   end

   assign pass = done && (err_count == CNT_W'(0));

endmodule
